// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed memory with one-cycle read
// latency and no byte enables; sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int p_MemWordAddrBits = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic        i_Store,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Address,
  input  logic [31:0] i_StoreData,
  output logic        o_Done,
  output logic        o_Error,
  output logic [31:0] o_LoadData,
  output logic        o_MemWriteEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataOut,
  input  logic [31:0] i_MemDataIn
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_MERGE, S_WRITE, S_DONE
  } state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;

  function automatic logic req_error(input logic st, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = |addr[1:0];
      3'b100:  bad = st;
      3'b101:  bad = st | addr[0];
      default: bad = 1'b1;
    endcase
    if ((addr >> (p_MemWordAddrBits + 2)) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] res;
    byte_sh = word >> {off, 3'b000};
    half_sh = word >> {off[1], 4'b0000};
    case (f3)
      3'b000:  res = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  res = {24'd0, byte_sh[7:0]};
      3'b001:  res = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  res = {16'd0, half_sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word, input logic [31:0] data);
    logic [31:0] res;
    res = word;
    if (f3 == 3'b000) res[{off, 3'b000} +: 8] = data[7:0];
    else              res[{off[1], 4'b0000} +: 16] = data[15:0];
    return res;
  endfunction

  // Word address is a plain truncation of the latched byte address.
  assign o_MemAddress = {2'b00, addr_q[31:2]};

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state            <= S_IDLE;
      o_Ready          <= 1'b1;
      o_Done           <= 1'b0;
      o_Error          <= 1'b0;
      o_LoadData       <= '0;
      o_MemWriteEnable <= 1'b0;
      o_MemDataOut     <= '0;
      store_q          <= 1'b0;
      funct3_q         <= '0;
      addr_q           <= '0;
      store_data_q     <= '0;
    end else begin
      o_Done           <= 1'b0;
      o_Error          <= 1'b0;
      o_MemWriteEnable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Valid && o_Ready) begin
            store_q      <= i_Store;
            funct3_q     <= i_Funct3;
            addr_q       <= i_Address;
            store_data_q <= i_StoreData;
            o_Ready      <= 1'b0;
            if (req_error(i_Store, i_Funct3, i_Address)) begin
              state   <= S_DONE;
              o_Done  <= 1'b1;
              o_Error <= 1'b1;
            end else if (i_Store && i_Funct3 == 3'b010) begin
              state            <= S_WRITE;
              o_MemWriteEnable <= 1'b1;
              o_MemDataOut     <= i_StoreData;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: state <= store_q ? S_MERGE : S_CAPTURE;
        S_CAPTURE: begin
          o_LoadData <= load_extend(funct3_q, addr_q[1:0], i_MemDataIn);
          o_Done     <= 1'b1;
          state      <= S_DONE;
        end
        S_MERGE: begin
          o_MemDataOut     <= store_merge(funct3_q, addr_q[1:0], i_MemDataIn, store_data_q);
          o_MemWriteEnable <= 1'b1;
          state            <= S_WRITE;
        end
        S_WRITE: begin
          o_Done <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          o_Ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          o_Ready <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random loads/stores against a 64-word
// memory, checked with a behavioural model of RV32I load/store semantics.
module tb_load_store_unit;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_Valid, i_Store;
  logic [2:0]  i_Funct3;
  logic [31:0] i_Address, i_StoreData;
  logic        o_Ready, o_Done, o_Error, o_MemWriteEnable;
  logic [31:0] o_LoadData, o_MemAddress, o_MemDataOut;
  logic [31:0] mem_rdata;

  logic [31:0] mem_arr [0:63];
  logic        tb_wr;
  logic [5:0]  tb_wr_idx;
  logic [31:0] tb_wr_data;

  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_load;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.p_MemWordAddrBits(P)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Store(i_Store), .i_Funct3(i_Funct3), .i_Address(i_Address),
    .i_StoreData(i_StoreData), .o_Done(o_Done), .o_Error(o_Error),
    .o_LoadData(o_LoadData), .o_MemWriteEnable(o_MemWriteEnable),
    .o_MemAddress(o_MemAddress), .o_MemDataOut(o_MemDataOut),
    .i_MemDataIn(mem_rdata)
  );

  // Synchronous memory: registered read, write enable, bench preload port.
  always @(posedge clk) begin
    if (tb_wr) mem_arr[tb_wr_idx] <= tb_wr_data;
    else if (o_MemWriteEnable) mem_arr[o_MemAddress[5:0]] <= o_MemDataOut;
    mem_rdata <= mem_arr[o_MemAddress[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit model_error(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    sz = size_of(f3);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (st && f3 >= 3'd4) return 1'b1;
    if ((a % sz) != 0) return 1'b1;
    if (64'(a) >= (64'd1 << (P + 2))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    if (size_of(f3) == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size_of(f3) == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] old, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    int sz;
    sz = size_of(f3);
    sh = 8 * int'(a % 4);
    if (sz == 4) mask = 32'hFFFFFFFF;
    else mask = ((32'd1 << (8 * sz)) - 32'd1) << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
    int lat, we_cnt, idx, exp_lat;
    bit done, e;
    logic [31:0] we_addr, we_data, exp_word;
    for (int k = 0; k < 10 && !o_Ready; k++) begin
      @(posedge clk); #1;
    end
    check({tag, " ready"}, 32'(o_Ready), 32'd1);
    e = model_error(st, f3, a);
    idx = int'((a >> 2) & 32'd63);
    exp_lat = e ? 1 : (st ? ((f3 == 3'd2) ? 2 : 4) : 3);
    exp_word = ref_mem[idx];
    if (!e && st) exp_word = model_store(f3, a, ref_mem[idx], d);
    if (!e && !st) exp_load = model_load(f3, a, ref_mem[idx]);
    i_Valid = 1'b1; i_Store = st; i_Funct3 = f3; i_Address = a; i_StoreData = d;
    @(posedge clk); #1;
    i_Valid = 1'b0;
    i_StoreData = $urandom;
    lat = 1; done = 1'b0; we_cnt = 0; we_addr = '0; we_data = '0;
    for (int k = 0; k < 12; k++) begin
      if (o_MemWriteEnable) begin
        we_cnt++; we_addr = o_MemAddress; we_data = o_MemDataOut;
      end
      if (o_Done) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " error"}, 32'(o_Error), 32'(e));
    check({tag, " we_count"}, 32'(we_cnt), (st && !e) ? 32'd1 : 32'd0);
    if (st && !e) begin
      check({tag, " we_addr"}, we_addr, 32'(idx));
      check({tag, " we_data"}, we_data, exp_word);
    end
    check({tag, " load_data"}, o_LoadData, exp_load);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(o_Done), 32'd0);
    check({tag, " mem_word"}, mem_arr[idx], exp_word);
    ref_mem[idx] = exp_word;
  endtask

  initial begin
    int we_bad, dones, wes, idx;
    logic [2:0] legal [5];
    logic [2:0] f3;
    logic [31:0] a;
    bit st;
    legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;
    rst_n = 1'b0; i_Valid = 1'b0; i_Store = 1'b0; i_Funct3 = '0;
    i_Address = '0; i_StoreData = '0; tb_wr = 1'b0; tb_wr_idx = '0; tb_wr_data = '0;
    exp_load = '0;

    // Preload memory while the unit is held in reset.
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (i == 5) ? 32'h8899AABB : $urandom;
      tb_wr = 1'b1; tb_wr_idx = 6'(i); tb_wr_data = ref_mem[i];
      @(posedge clk); #1;
    end
    tb_wr = 1'b0;

    check("rst ready", 32'(o_Ready), 32'd1);
    check("rst done", 32'(o_Done), 32'd0);
    check("rst error", 32'(o_Error), 32'd0);
    check("rst we", 32'(o_MemWriteEnable), 32'd0);
    check("rst load_data", o_LoadData, 32'd0);
    check("rst mem_addr", o_MemAddress, 32'd0);
    check("rst mem_dout", o_MemDataOut, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(1'b0, 3'b000, 32'h16, 32'h0, "lb_16");
    check("lb_16 value", o_LoadData, 32'hFFFFFF99);
    run_req(1'b0, 3'b101, 32'h14, 32'h0, "lhu_14");
    check("lhu_14 value", o_LoadData, 32'h0000AABB);
    run_req(1'b0, 3'b010, 32'h14, 32'h0, "lw_14");
    check("lw_14 value", o_LoadData, 32'h8899AABB);
    run_req(1'b1, 3'b000, 32'h17, 32'h123456CC, "sb_17");
    check("sb_17 value", mem_arr[5], 32'hCC99AABB);
    run_req(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, "sw_0");
    check("sw_0 value", mem_arr[0], 32'hDEADBEEF);
    run_req(1'b0, 3'b010, 32'h2, 32'h0, "lw_misaligned");
    run_req(1'b1, 3'b001, 32'h3, 32'h5555, "sh_misaligned");
    run_req(1'b1, 3'b100, 32'h8, 32'h77, "store_f3_100");
    run_req(1'b0, 3'b010, 32'h00040000, 32'h0, "lw_out_of_range");
    run_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, "lw_top");
    run_req(1'b0, 3'b110, 32'h10, 32'h0, "f3_110");
    run_req(1'b1, 3'b001, 32'h12, 32'hABCD1234, "sh_12");

    // i_Valid held high: one accept per IDLE visit, 4 cycles per LW.
    exp_load = ref_mem[8];
    i_Valid = 1'b1; i_Store = 1'b0; i_Funct3 = 3'b010; i_Address = 32'h20;
    dones = 0; wes = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_Done) dones++;
      if (o_MemWriteEnable) wes++;
    end
    i_Valid = 1'b0;
    check("held_valid dones", 32'(dones), 32'd10);
    check("held_valid writes", 32'(wes), 32'd0);
    check("held_valid load_data", o_LoadData, exp_load);

    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(18, 31));
      run_req(st, f3, a, $urandom, $sformatf("rnd%0d", n));
    end

    // Reset during the MERGE cycle of a byte store.
    idx = 9;
    i_Valid = 1'b1; i_Store = 1'b1; i_Funct3 = 3'b000; i_Address = 32'h25; i_StoreData = 32'h5A;
    @(posedge clk); #1;
    i_Valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst ready", 32'(o_Ready), 32'd1);
    check("midrst done", 32'(o_Done), 32'd0);
    check("midrst we", 32'(o_MemWriteEnable), 32'd0);
    check("midrst load_data", o_LoadData, 32'd0);
    check("midrst mem_addr", o_MemAddress, 32'd0);
    check("midrst mem_dout", o_MemDataOut, 32'd0);
    we_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (o_MemWriteEnable) we_bad++;
    end
    check("midrst no_write", 32'(we_bad), 32'd0);
    rst_n = 1'b1;
    exp_load = '0;
    @(posedge clk); #1;
    check("midrst ready_after", 32'(o_Ready), 32'd1);
    check("midrst mem_word", mem_arr[idx], ref_mem[idx]);
    run_req(1'b0, 3'b100, 32'h25, 32'h0, "post_reset_lbu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
